// File: rtl/alu_serial.sv
// alu_serial: multi-cycle Hack ALU that adds or ANDs SLICE bits per cycle
// through a registered carry chain, with valid/ready on request and result.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_valid / in_ready      request handshake (ready only when idle)
//   x, y                     WIDTH-bit operands
//   zx nx zy ny f no         Hack control bits, captured at acceptance
//   out_valid / out_ready    result handshake
//   out, zr, ng              result, zero flag, sign flag
//   carry, ovf               add carry-out / signed overflow (0 for AND)

module alu_serial #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             zx,
   input  logic             nx,
   input  logic             zy,
   input  logic             ny,
   input  logic             f,
   input  logic             no,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng,
   output logic             carry,
   output logic             ovf
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam int MSB = WIDTH - 1;

   if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad
      $error("alu_serial: SLICE must divide WIDTH");
   end

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [WIDTH-1:0] xa;
   logic [WIDTH-1:0] ya;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;
   logic             cy;
   logic             f_r;
   logic             no_r;

   logic [WIDTH-1:0] xz;
   logic [WIDTH-1:0] yz;
   logic [WIDTH-1:0] xa_in;
   logic [WIDTH-1:0] ya_in;
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] res_nxt;
   logic [SLICE-1:0] xs;
   logic [SLICE-1:0] ys;
   logic [SLICE-1:0] ps;
   logic [SLICE:0]   sum;
   logic             last;
   logic             accept;
   int               base;

   // Hack operand preprocessing, applied once at acceptance
   always_comb begin
      xz    = zx ? '0 : x;
      yz    = zy ? '0 : y;
      xa_in = nx ? ~xz : xz;
      ya_in = ny ? ~yz : yz;
   end

   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign last      = (cnt == LAST);

   // Current slice: select by shifting, then merge the partial result
   // back into its position in the accumulator.
   always_comb begin
      base    = int'(cnt) * SLICE;
      xs      = SLICE'(xa >> base);
      ys      = SLICE'(ya >> base);
      sum     = {1'b0, xs} + {1'b0, ys} + {{SLICE{1'b0}}, cy};
      ps      = f_r ? sum[SLICE-1:0] : (xs & ys);
      mask    = WIDTH'({SLICE{1'b1}}) << base;
      acc_nxt = (acc & ~mask) | (WIDTH'(ps) << base);
      res_nxt = no_r ? ~acc_nxt : acc_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept) state_nxt = CALC;
         CALC: if (last) state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xa    <= '0;
         ya    <= '0;
         acc   <= '0;
         cnt   <= '0;
         cy    <= 1'b0;
         f_r   <= 1'b0;
         no_r  <= 1'b0;
         out   <= '0;
         zr    <= 1'b0;
         ng    <= 1'b0;
         carry <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  xa   <= xa_in;
                  ya   <= ya_in;
                  f_r  <= f;
                  no_r <= no;
                  acc  <= '0;
                  cnt  <= '0;
                  cy   <= 1'b0;
               end
            end
            CALC: begin
               acc <= acc_nxt;
               cy  <= f_r & sum[SLICE];
               cnt <= cnt + 1'b1;
               if (last) begin
                  out   <= res_nxt;
                  zr    <= (res_nxt == '0);
                  ng    <= res_nxt[MSB];
                  carry <= f_r & sum[SLICE];
                  // overflow judged on the raw sum, before the no inversion
                  ovf   <= f_r & (xa[MSB] == ya[MSB])
                               & (acc_nxt[MSB] != xa[MSB]);
               end
            end
            DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: directed checks of alu_serial at SLICE=4, 16 and 1,
// covering Hack ops, flags, latency, backpressure and async reset.

module tb_alu_serial;

   localparam int W = 16;
   localparam int SL[3] = '{4, 16, 1};

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         zx, nx, zy, ny, f, no;
   logic         iv[3];
   logic         ir[3];
   logic         ov[3];
   logic         ordy[3];
   logic [W-1:0] res[3];
   logic         zr[3];
   logic         ng[3];
   logic         cy[3];
   logic         of[3];

   int checks = 0;
   int errors = 0;
   int lat;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      alu_serial #(
         .WIDTH(W),
         .SLICE(SL[g])
      ) u_dut (
         .clk      (clk),
         .rst      (rst),
         .in_valid (iv[g]),
         .in_ready (ir[g]),
         .x        (x),
         .y        (y),
         .zx       (zx),
         .nx       (nx),
         .zy       (zy),
         .ny       (ny),
         .f        (f),
         .no       (no),
         .out_valid(ov[g]),
         .out_ready(ordy[g]),
         .out      (res[g]),
         .zr       (zr[g]),
         .ng       (ng[g]),
         .carry    (cy[g]),
         .ovf      (of[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic op(input int d, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [5:0] c,
                     input bit tgl, output int l);
      @(negedge clk);
      x = a;
      y = b;
      {zx, nx, zy, ny, f, no} = c;
      iv[d] = 1'b1;
      #1 chk("in_ready", 32'(ir[d]), 1);
      @(posedge clk);
      #1 iv[d] = 1'b0;
      l = 0;
      while (!ov[d] && l < 40) begin
         if (tgl) begin
            x = W'($urandom);
            y = W'($urandom);
            {zx, nx, zy, ny, f, no} = 6'($urandom);
         end
         @(posedge clk);
         #1 l++;
      end
      if (!ov[d]) chk("timeout", 32'(ov[d]), 1);
   endtask

   task automatic expect_res(input int d, input string tag,
                             input logic [W-1:0] eo, input logic ez,
                             input logic en, input logic ec,
                             input logic eovf);
      chk({tag, ".out"}, 32'(res[d]), 32'(eo));
      chk({tag, ".zr"}, 32'(zr[d]), 32'(ez));
      chk({tag, ".ng"}, 32'(ng[d]), 32'(en));
      chk({tag, ".carry"}, 32'(cy[d]), 32'(ec));
      chk({tag, ".ovf"}, 32'(of[d]), 32'(eovf));
   endtask

   task automatic ack(input int d);
      ordy[d] = 1'b1;
      @(posedge clk);
      #1 ordy[d] = 1'b0;
      chk("ack.valid", 32'(ov[d]), 0);
      chk("ack.ready", 32'(ir[d]), 1);
   endtask

   initial begin
      rst = 1'b1;
      x = '0;
      y = '0;
      {zx, nx, zy, ny, f, no} = 6'b0;
      for (int i = 0; i < 3; i++) begin
         iv[i]   = 1'b0;
         ordy[i] = 1'b0;
      end
      #2;
      chk("rst.valid", 32'(ov[0]), 0);
      chk("rst.ready", 32'(ir[0]), 0);
      expect_res(0, "rst", 16'h0000, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 chk("rel.ready", 32'(ir[0]), 1);

      op(0, 16'h0005, 16'h0003, 6'b000010, 0, lat);
      chk("add.lat", 32'(lat), 4);
      expect_res(0, "add", 16'h0008, 0, 0, 0, 0);
      ack(0);

      op(0, 16'hFFFF, 16'h0001, 6'b000010, 0, lat);
      expect_res(0, "wrap", 16'h0000, 1, 0, 1, 0);
      ack(0);

      op(0, 16'h7FFF, 16'h0001, 6'b000010, 0, lat);
      expect_res(0, "ovf", 16'h8000, 0, 1, 0, 1);
      ack(0);

      op(0, 16'h0000, 16'h1234, 6'b001110, 0, lat);
      expect_res(0, "xm1", 16'hFFFF, 0, 1, 0, 0);
      ack(0);

      op(0, 16'hABCD, 16'h1234, 6'b101010, 0, lat);
      expect_res(0, "zero", 16'h0000, 1, 0, 0, 0);
      ack(0);

      op(0, 16'h0F0F, 16'h00FF, 6'b000000, 0, lat);
      expect_res(0, "and", 16'h000F, 0, 0, 0, 0);
      ack(0);

      // -x = ~(x + 0xFFFF): the add carries out of the MSB
      op(0, 16'h0003, 16'h5555, 6'b001111, 0, lat);
      expect_res(0, "negx", 16'hFFFD, 0, 1, 1, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp.valid", 32'(ov[0]), 1);
         chk("bp.ready", 32'(ir[0]), 0);
         expect_res(0, "bp", 16'hFFFD, 0, 1, 1, 0);
      end
      ack(0);
      repeat (2) @(negedge clk);
      expect_res(0, "hold", 16'hFFFD, 0, 1, 1, 0);

      op(0, 16'h1234, 16'h1111, 6'b000010, 1, lat);
      expect_res(0, "tgl", 16'h2345, 0, 0, 0, 0);
      ack(0);

      op(0, 16'h7FFF, 16'h0001, 6'b000010, 0, lat);
      expect_res(0, "pre", 16'h8000, 0, 1, 0, 1);
      ack(0);

      @(negedge clk);
      x = 16'h1000;
      y = 16'h0100;
      {zx, nx, zy, ny, f, no} = 6'b000010;
      iv[0] = 1'b1;
      @(posedge clk);
      #1 iv[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("arst.valid", 32'(ov[0]), 0);
      chk("arst.ready", 32'(ir[0]), 0);
      expect_res(0, "arst", 16'h0000, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("abort.valid", 32'(ov[0]), 0);
      end
      op(0, 16'h0001, 16'h0001, 6'b000010, 0, lat);
      chk("post.lat", 32'(lat), 4);
      expect_res(0, "post", 16'h0002, 0, 0, 0, 0);
      ack(0);

      for (int d = 1; d < 3; d++) begin
         op(d, 16'hFFFF, 16'h0001, 6'b000010, 0, lat);
         chk("sl.lat", 32'(lat), 32'(W / SL[d]));
         expect_res(d, "sl.wrap", 16'h0000, 1, 0, 1, 0);
         ack(d);
         op(d, 16'h7FFF, 16'h0001, 6'b000010, 0, lat);
         chk("sl.lat2", 32'(lat), 32'(W / SL[d]));
         expect_res(d, "sl.ovf", 16'h8000, 0, 1, 0, 1);
         ack(d);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
